// File: rtl/fish_pkg.sv
// Shared fish types and screen constants for the movement generator, tracker and renderer.
package fish_pkg;

  localparam int unsigned H_MAX   = 640;
  localparam int unsigned V_MAX   = 480;
  localparam int unsigned POS_W   = 10;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned WAY_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWIM   = 2'd1,
    HOOKED = 2'd2,
    DONE   = 2'd3
  } fish_state_e;

  typedef enum logic [WAY_W-1:0] {
    WAY_LEFT  = 2'd0,
    WAY_RIGHT = 2'd1,
    WAY_UP    = 2'd2,
    WAY_RSVD  = 2'd3
  } fish_way_e;

  // The reserved encoding swims left.
  function automatic fish_way_e norm_way(input logic [WAY_W-1:0] w);
    return (w == 2'd3) ? WAY_LEFT : fish_way_e'(w);
  endfunction

endpackage

// File: rtl/fish_hit_box.sv
// Combinational point-in-box test against a FISH_W x FISH_H box anchored at its top-left corner.
module fish_hit_box
  import fish_pkg::*;
#(
  parameter int unsigned FISH_W = 32,
  parameter int unsigned FISH_H = 16
) (
  input  logic [POS_W-1:0] px,
  input  logic [POS_W-1:0] py,
  input  logic [POS_W-1:0] box_x,
  input  logic [POS_W-1:0] box_y,
  output logic             inside_c
);

  logic [ARITH_W-1:0] px_w, py_w, bx_w, by_w;

  assign px_w = ARITH_W'(px);
  assign py_w = ARITH_W'(py);
  assign bx_w = ARITH_W'(box_x);
  assign by_w = ARITH_W'(box_y);

  // Widened so the far edge cannot wrap near the screen border.
  assign inside_c = (px_w >= bx_w) && (px_w < bx_w + ARITH_W'(FISH_W)) &&
                    (py_w >= by_w) && (py_w < by_w + ARITH_W'(FISH_H));

endmodule

// File: rtl/fish_tracker.sv
// Fish position integrator and life-cycle FSM (spawn, swim, hooked, done) with scan hit flag.
// Optional FISH_RELEASE_EN: dropping the hook while hooked returns the fish to SWIM.
module fish_tracker #(
  parameter int unsigned FISH_W    = 32,
  parameter int unsigned FISH_H    = 16,
  parameter int unsigned H_MAX     = fish_pkg::H_MAX,
  parameter int unsigned V_MAX     = fish_pkg::V_MAX,
  parameter int unsigned START_V   = 240,
  parameter int unsigned SURFACE_V = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          appear,
  input  logic [fish_pkg::WAY_W-1:0]    way,
  input  logic [fish_pkg::STEP_W-1:0]   hm,
  input  logic [fish_pkg::STEP_W-1:0]   vm,
  input  logic                          hook_active,
  input  logic [fish_pkg::POS_W-1:0]    hook_x,
  input  logic [fish_pkg::POS_W-1:0]    hook_y,
  input  logic [fish_pkg::POS_W-1:0]    h,
  input  logic [fish_pkg::POS_W-1:0]    v,
  output logic [fish_pkg::POS_W-1:0]    fish_x,
  output logic [fish_pkg::POS_W-1:0]    fish_y,
  output logic [1:0]                    state,
  output logic                          caught,
  output logic                          landed,
  output logic                          escaped,
  output logic                          pixel_on
);
  import fish_pkg::*;

  localparam int unsigned AW = ARITH_W;
  localparam logic [AW-1:0] X_LIM    = AW'(H_MAX - FISH_W);
  localparam logic [AW-1:0] Y_LIM    = AW'(V_MAX - FISH_H);
  localparam logic [AW-1:0] HALF_W   = AW'(FISH_W / 2);
  localparam logic [AW-1:0] START_Y  = AW'(START_V);
  localparam logic [AW-1:0] SURF_Y   = AW'(SURFACE_V);
  localparam logic [AW-1:0] UP_X     = AW'(H_MAX / 2 - FISH_W / 2);

  fish_state_e        state_q, state_nx;
  fish_way_e          way_q, way_nx, spawn_way;
  logic [AW-1:0]      x_w, y_w, hm_w, vm_w, hook_x_w, hook_y_w;
  logic [AW-1:0]      x_nx, y_nx, hooked_x, hooked_y;
  logic               caught_nx, landed_nx, escaped_nx, pixel_nx;
  logic               catch_hit_c, pix_hit_c, catch_c, escape_c, land_c, release_c;

  fish_hit_box #(.FISH_W(FISH_W), .FISH_H(FISH_H)) u_catch_box (
    .px(hook_x), .py(hook_y), .box_x(fish_x), .box_y(fish_y), .inside_c(catch_hit_c)
  );

  fish_hit_box #(.FISH_W(FISH_W), .FISH_H(FISH_H)) u_pixel_box (
    .px(h), .py(v), .box_x(fish_x), .box_y(fish_y), .inside_c(pix_hit_c)
  );

  assign x_w       = AW'(fish_x);
  assign y_w       = AW'(fish_y);
  assign hm_w      = AW'(hm);
  assign vm_w      = AW'(vm);
  assign hook_x_w  = AW'(hook_x);
  assign hook_y_w  = AW'(hook_y);
  assign spawn_way = norm_way(way);

  assign catch_c = hook_active && catch_hit_c;
  assign land_c  = (hook_y_w < SURF_Y);

`ifdef FISH_RELEASE_EN
  assign release_c = !hook_active;
`else
  assign release_c = 1'b0;
`endif

  // Escape is judged against the step about to be applied.
  always_comb begin
    escape_c = 1'b0;
    unique case (way_q)
      WAY_RIGHT: escape_c = (x_w + hm_w > X_LIM);
      WAY_UP:    escape_c = (y_w <= vm_w);
      default:   escape_c = (x_w <= hm_w);
    endcase
  end

  // Hooked fish is centred on the hook tip and kept on screen.
  always_comb begin
    hooked_x = (hook_x_w < HALF_W) ? '0 : hook_x_w - HALF_W;
    if (hooked_x > X_LIM) hooked_x = X_LIM;
    hooked_y = (hook_y_w > Y_LIM) ? Y_LIM : hook_y_w;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      way_q    <= WAY_LEFT;
      fish_x   <= '0;
      fish_y   <= '0;
      caught   <= 1'b0;
      landed   <= 1'b0;
      escaped  <= 1'b0;
      pixel_on <= 1'b0;
    end else begin
      state_q  <= state_nx;
      way_q    <= way_nx;
      fish_x   <= POS_W'(x_nx);
      fish_y   <= POS_W'(y_nx);
      caught   <= caught_nx;
      landed   <= landed_nx;
      escaped  <= escaped_nx;
      pixel_on <= pixel_nx;
    end
  end

  // Despawn outranks every other transition; catch outranks escape.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:   if (appear) state_nx = SWIM;
      SWIM: begin
        if (!appear)       state_nx = IDLE;
        else if (catch_c)  state_nx = HOOKED;
        else if (escape_c) state_nx = DONE;
      end
      HOOKED: begin
        if (!appear)        state_nx = IDLE;
        else if (land_c)    state_nx = DONE;
        else if (release_c) state_nx = SWIM;
      end
      DONE:   if (!appear) state_nx = IDLE;
    endcase
  end

  always_comb begin
    way_nx     = way_q;
    x_nx       = x_w;
    y_nx       = y_w;
    caught_nx  = 1'b0;
    landed_nx  = 1'b0;
    escaped_nx = 1'b0;
    pixel_nx   = ((state_q == SWIM) || (state_q == HOOKED)) && pix_hit_c;
    unique case (state_q)
      IDLE: begin
        if (appear) begin
          way_nx = spawn_way;
          unique case (spawn_way)
            WAY_RIGHT: begin x_nx = '0;   y_nx = START_Y; end
            WAY_UP:    begin x_nx = UP_X; y_nx = Y_LIM;   end
            default:   begin x_nx = X_LIM; y_nx = START_Y; end
          endcase
        end
      end
      SWIM: begin
        if (appear) begin
          if (catch_c)       caught_nx  = 1'b1;
          else if (escape_c) escaped_nx = 1'b1;
          else begin
            unique case (way_q)
              WAY_RIGHT: x_nx = x_w + hm_w;
              WAY_UP:    y_nx = y_w - vm_w;
              default:   x_nx = x_w - hm_w;
            endcase
          end
        end
      end
      HOOKED: begin
        if (appear) begin
          landed_nx = land_c;
          if (land_c || !release_c) begin
            x_nx = hooked_x;
            y_nx = hooked_y;
          end
        end
      end
      DONE: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_fish_tracker.sv
// Directed scoreboard bench for fish_tracker: spawn, swim, escape, catch, hooked tracking, landing, scan hits, reset.
module tb_fish_tracker;
  import fish_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       appear = 1'b0;
  logic [1:0] way = 2'd0;
  logic [2:0] hm = 3'd0;
  logic [2:0] vm = 3'd0;
  logic       hook_active = 1'b0;
  logic [9:0] hook_x = 10'd1023;
  logic [9:0] hook_y = 10'd1023;
  logic [9:0] h = 10'd1023;
  logic [9:0] v = 10'd1023;
  logic [9:0] fish_x, fish_y;
  logic [1:0] state;
  logic       caught, landed, escaped, pixel_on;

  typedef struct packed {
    logic [1:0] st;
    logic [9:0] x;
    logic [9:0] y;
    logic       c;
    logic       l;
    logic       e;
    logic       p;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  fish_tracker dut (
    .clk(clk), .rst(rst), .appear(appear), .way(way), .hm(hm), .vm(vm),
    .hook_active(hook_active), .hook_x(hook_x), .hook_y(hook_y), .h(h), .v(v),
    .fish_x(fish_x), .fish_y(fish_y), .state(state), .caught(caught),
    .landed(landed), .escaped(escaped), .pixel_on(pixel_on)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [1:0] st, input int x, input int y,
                          input logic c, input logic l, input logic e, input logic p);
    obs_t o;
    o.st = st; o.x = 10'(x); o.y = 10'(y);
    o.c = c; o.l = l; o.e = e; o.p = p;
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    obs_t  got, want;
    string tag;
    got.st = state; got.x = fish_x; got.y = fish_y;
    got.c = caught; got.l = landed; got.e = escaped; got.p = pixel_on;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed output with no expectation queued");
      return;
    end
    want = exp_q.pop_front();
    tag  = tag_q.pop_front();
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed st=%0d x=%0d y=%0d c=%0b l=%0b e=%0b p=%0b expected st=%0d x=%0d y=%0d c=%0b l=%0b e=%0b p=%0b",
             tag, got.st, got.x, got.y, got.c, got.l, got.e, got.p,
             want.st, want.x, want.y, want.c, want.l, want.e, want.p);
    end
  endtask

  // Queue the expectation for the edge about to happen, then compare just after it.
  task automatic step(input string tag, input logic [1:0] st, input int x, input int y,
                      input logic c, input logic l, input logic e, input logic p);
    push_exp(tag, st, x, y, c, l, e, p);
    @(posedge clk); #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    push_exp("reset", IDLE, 0, 0, 0, 0, 0, 0);
    compare();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Right swimmer spawns at the left edge, then ten one-pixel steps.
    appear = 1'b1; way = 2'd1;
    step("spawn_right", SWIM, 0, 240, 0, 0, 0, 0);
    hm = 3'd1;
    for (int i = 0; i < 9; i++) tick();
    step("right_x10", SWIM, 10, 240, 0, 0, 0, 0);
    way = 2'd0;
    step("way_ignored", SWIM, 11, 240, 0, 0, 0, 0);
    hm = 3'd0;

    // Scan hits against the box at (11,240).
    h = 10'd21; v = 10'd245;
    step("pix_inside", SWIM, 11, 240, 0, 0, 0, 1);
    h = 10'd43;
    step("pix_right_edge_out", SWIM, 11, 240, 0, 0, 0, 0);
    h = 10'd42; v = 10'd255;
    step("pix_corner_in", SWIM, 11, 240, 0, 0, 0, 1);
    v = 10'd256;
    step("pix_bottom_out", SWIM, 11, 240, 0, 0, 0, 0);
    h = 10'd10; v = 10'd240;
    step("pix_left_out", SWIM, 11, 240, 0, 0, 0, 0);
    h = 10'd1023; v = 10'd1023;
    appear = 1'b0;
    step("despawn_swim", IDLE, 11, 240, 0, 0, 0, 0);

    // Left swimmer from the right edge down to the escape boundary.
    appear = 1'b1; way = 2'd0;
    step("spawn_left", SWIM, 608, 240, 0, 0, 0, 0);
    hm = 3'd4;
    step("left_step", SWIM, 604, 240, 0, 0, 0, 0);
    for (int i = 0; i < 149; i++) tick();
    step("left_x4", SWIM, 4, 240, 0, 0, 0, 0);
    step("escape", DONE, 4, 240, 0, 0, 1, 0);
    hm = 3'd0;
    step("done_hold", DONE, 4, 240, 0, 0, 0, 0);
    appear = 1'b0;
    step("done_to_idle", IDLE, 4, 240, 0, 0, 0, 0);

    // Right swimmer to x=100, then catch with a simultaneous step.
    appear = 1'b1; way = 2'd1;
    step("spawn_right2", SWIM, 0, 240, 0, 0, 0, 0);
    hm = 3'd5;
    for (int i = 0; i < 19; i++) tick();
    step("right_x100", SWIM, 100, 240, 0, 0, 0, 0);
    hm = 3'd1; hook_active = 1'b1; hook_x = 10'd110; hook_y = 10'd250;
    step("catch", HOOKED, 100, 240, 1, 0, 0, 0);
    hm = 3'd0;
    step("hooked_follow", HOOKED, 94, 250, 0, 0, 0, 0);
    hook_x = 10'd5; hook_y = 10'd100;
    step("hooked_clamp_left", HOOKED, 0, 100, 0, 0, 0, 0);
    hook_x = 10'd639; hook_y = 10'd470;
    step("hooked_clamp_br", HOOKED, 608, 464, 0, 0, 0, 0);

    hook_active = 1'b0;
`ifdef FISH_RELEASE_EN
    step("release", SWIM, 608, 464, 0, 0, 0, 0);
    hook_active = 1'b1; hook_x = 10'd610;
    step("recatch", HOOKED, 608, 464, 1, 0, 0, 0);
`else
    step("no_release", HOOKED, 608, 464, 0, 0, 0, 0);
    hook_active = 1'b1; hook_x = 10'd610;
    step("hooked_track", HOOKED, 594, 464, 0, 0, 0, 0);
`endif
    hook_x = 10'd110; hook_y = 10'd250;
    step("hooked_back", HOOKED, 94, 250, 0, 0, 0, 0);
    hook_y = 10'd30;
    step("landed", DONE, 94, 30, 0, 1, 0, 0);
    h = 10'd100; v = 10'd35;
    step("done_no_pixel", DONE, 94, 30, 0, 0, 0, 0);
    h = 10'd1023; v = 10'd1023; hook_active = 1'b0;
    appear = 1'b0;
    step("landed_to_idle", IDLE, 94, 30, 0, 0, 0, 0);

    // Upward swimmer ignores the horizontal step.
    appear = 1'b1; way = 2'd2;
    step("spawn_up", SWIM, 304, 464, 0, 0, 0, 0);
    vm = 3'd4; hm = 3'd3;
    step("up_step", SWIM, 304, 460, 0, 0, 0, 0);
    vm = 3'd0; hm = 3'd0; appear = 1'b0;
    step("despawn_up", IDLE, 304, 460, 0, 0, 0, 0);

    // Reserved way swims left; then asynchronous reset mid-swim.
    appear = 1'b1; way = 2'd3;
    step("spawn_rsvd", SWIM, 608, 240, 0, 0, 0, 0);
    hm = 3'd4;
    step("rsvd_left", SWIM, 604, 240, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    push_exp("async_reset", IDLE, 0, 0, 0, 0, 0, 0);
    compare();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fish_tracker.md
# fish_tracker

Consumer of the per-fish step strobes (`hm`/`vm`) produced by the fish movement generator. Integrates those steps into an on-screen fish position and runs the fish life cycle: spawn, swim, hooked, done. Reports catch, landing and escape events to the game controller. Drives a registered `pixel_on` flag that the VGA renderer uses for the current scan coordinate.

## Interface
Parameters:
- `FISH_W`, 32: fish box width, pixels
- `FISH_H`, 16: fish box height, pixels
- `H_MAX`, 640: visible width
- `V_MAX`, 480: visible height
- `START_V`, 240: spawn row for left/right swimmers
- `SURFACE_V`, 40: landing row while hooked

Ports:
- `clk`  in  1  system clock (single clock domain)
- `rst`  in  1  asynchronous, active-low reset
- `appear`  in  1  1 = fish exists; 0 = despawn
- `way`  in  2  0 = swim left, 1 = swim right, 2 = swim up, 3 = reserved (treated as 0)
- `hm`  in  3  horizontal step this cycle, pixels (0 = none)
- `vm`  in  3  vertical step this cycle, pixels (0 = none)
- `hook_active`  in  1  hook is in the water
- `hook_x`, `hook_y`  in  10 each  hook tip position
- `h`, `v`  in  10 each  current VGA scan coordinate
- `fish_x`, `fish_y`  out  10 each  fish box top-left corner
- `state`  out  2  IDLE=0, SWIM=1, HOOKED=2, DONE=3
- `caught`  out  1  one-cycle pulse on SWIM→HOOKED
- `landed`  out  1  one-cycle pulse on HOOKED→DONE
- `escaped`  out  1  one-cycle pulse on SWIM→DONE
- `pixel_on`  out  1  (h,v) lies inside a live fish box

## Operation
- IDLE: waits for `appear`=1, then loads the spawn position and goes to SWIM.
  - way 0: x = H_MAX−FISH_W, y = START_V
  - way 1: x = 0, y = START_V
  - way 2: x = H_MAX/2−FISH_W/2, y = V_MAX−FISH_H
- `way` is latched at spawn. Later changes to `way` are ignored until the next spawn.
- SWIM movement:
  - way 0: x −= hm
  - way 1: x += hm
  - way 2: y −= vm
  - The unused axis step is ignored.
- SWIM escape, checked on the step about to be applied:
  - way 0: x ≤ hm
  - way 1: x + hm > H_MAX − FISH_W
  - way 2: y ≤ vm
  - On escape: go to DONE, pulse `escaped`, leave position unchanged.
- SWIM catch: `hook_active` and `hook_x` in [x, x+FISH_W) and `hook_y` in [y, y+FISH_H). On catch: go to HOOKED and pulse `caught`.
- Catch has priority over both escape and movement in the same cycle.
- HOOKED:
  - x = max(hook_x − FISH_W/2, 0) clamped to ≤ H_MAX−FISH_W
  - y = min(hook_y, V_MAX−FISH_H)
  - When `hook_y` < SURFACE_V: go to DONE and pulse `landed`.
- DONE: holds position, `pixel_on`=0. Returns to IDLE when `appear`=0.
- `appear`=0 in SWIM or HOOKED: go to IDLE next cycle with no event pulse. This has priority over every other transition.
- Arithmetic is done in 11 bits, with no wrap-around. Outputs are truncated to 10 bits after clamping.

## Timing
- Reset values: state=IDLE, fish_x=0, fish_y=0, caught/landed/escaped=0, pixel_on=0.
- Position and state update on the clk edge after the inputs are sampled (1-cycle latency).
- Event pulses are registered. Each is exactly one cycle wide and coincides with the first cycle of the new state.
- `pixel_on` is registered, 1 cycle after `h`/`v`. It is computed from the pre-update position and is 0 in IDLE and DONE.
- `appear` held at 1 in IDLE spawns on the next edge. Re-spawn requires `appear` to drop and rise again.
- `rst` asserted mid-operation forces all outputs to their reset values immediately (asynchronous).

## Configuration
- `FISH_RELEASE_EN` defined: `hook_active`=0 while HOOKED returns the fish to SWIM at its current position. No event pulse; the latched way is kept.
- `FISH_RELEASE_EN` undefined: HOOKED ignores `hook_active` and leaves only via landing or despawn.

## Structure
- Shared package `fish_pkg` holds:
  - the state enum (IDLE/SWIM/HOOKED/DONE)
  - the way encodings
  - H_MAX and V_MAX constants, shared with the movement generator and renderer
- One sub-module, `fish_hit_box`: combinational point-in-box compare, parameterised by FISH_W/FISH_H. Instantiated twice: hook catch and pixel scan.

## Test plan
- Reset, then `appear`=1 with way=1 and hm=1 for 10 cycles → fish_x=10, fish_y=240, state=SWIM.
- Way=0 spawn (x=608), hm=4 pulses → x decrements by 4. At x=4 the next hm=4 → state=DONE, `escaped` pulses for 1 cycle, x stays 4.
- SWIM at (100,240), `hook_active`=1, hook at (110,250), same cycle hm=1 → `caught` pulses, state=HOOKED, x not incremented.
- HOOKED with hook moved to (5,100) → fish_x=0, fish_y=100. Hook to y=30 → `landed` pulses, state=DONE. `appear`=0 → IDLE.
- Fish at (200,240), scan h=210, v=245 → `pixel_on`=1 one cycle later. h=232 → `pixel_on`=0.
- With and without FISH_RELEASE_EN, drop `hook_active` while HOOKED → returns to SWIM vs. stays in HOOKED. Assert `rst` mid-SWIM → all outputs reset immediately.
